rv32i_mc_ctrl: RTL and testbench
================================

// Module: rv32i_mc_ctrl
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences fetch, decode, execute, memory and writeback over the shared ALU/memory datapath.
//  Drives alu_op[1:0] into the ALU decoder (00 R-type, 10 I-type ALU, 01 forced ADD, 11 branch compare).
//  Handshakes with a single unified memory port; counts retired instructions and flags illegal opcodes / memory timeouts.
// PARAMETERS
//  MEM_TMO  default 16  max cycles mem_req may wait for mem_ready before trap; 0 disables timeout
//  CNT_W    default 32  width of instret counter
// PORTS
//  clk         in   1      core clock, all state updates on rising edge
//  rst_n       in   1      synchronous active-low reset, sampled on rising edge of clk
//  opcode      in   7      instr[6:0] from instruction register
//  zero        in   1      ALU zero flag (valid in BEQ state)
//  mem_ready   in   1      memory completes current access this cycle
//  mem_req     out  1      memory access request, held until mem_ready
//  mem_we      out  1      store qualifier (valid with mem_req)
//  adr_src     out  1      0: PC, 1: ALU result register as memory address
//  ir_we       out  1      load instruction register / old PC
//  pc_we       out  1      PC write (pc_update | (branch & zero))
//  reg_we      out  1      register-file write
//  alu_src_a   out  2      00 PC, 01 old PC, 10 rs1
//  alu_src_b   out  2      00 rs2, 01 imm, 10 const 4
//  result_src  out  2      00 ALU reg, 01 mem data, 10 ALU comb
//  alu_op      out  2      to ALU decoder, encoding as above
//  trap        out  1      sticky: illegal opcode or memory timeout
//  instret     out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state<=FETCH, instret<=0, trap<=0, wait cnt<=0. While rst_n=0 all outputs forced 0.
//  Outputs are decoded from state (Moore) except ir_we/pc_we/reg_we in memory states, gated by mem_ready.
//  FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=01, result_src=10; on mem_ready: ir_we=1, pc_we=1, ->DECODE; else stay.
//  DECODE: src_a=01, src_b=01, alu_op=01 (branch target). Next by opcode: 0000011/0100011->MEMADR, 0110011->EXEC_R,
//   0010011->EXEC_I, 1100011->BEQ, 1101111->JAL, other->TRAP.
//  MEMADR: src_a=10, src_b=01, alu_op=01; ->MEMRD if opcode[5]=0 else MEMWR.
//  MEMRD: mem_req=1, adr_src=1; on mem_ready ->MEMWB. MEMWR: mem_req=1, mem_we=1, adr_src=1; on mem_ready ->FETCH (retire).
//  MEMWB: result_src=01, reg_we=1; ->FETCH (retire).
//  EXEC_R: src_a=10, src_b=00, alu_op=00 ->ALUWB. EXEC_I: src_a=10, src_b=01, alu_op=10 ->ALUWB.
//  ALUWB: result_src=00, reg_we=1 ->FETCH (retire).
//  BEQ: src_a=10, src_b=00, alu_op=11, result_src=00, branch=1 (pc_we=zero) ->FETCH (retire).
//  JAL: src_a=01, src_b=10, alu_op=01, result_src=00, pc_we=1 (target from DECODE reg) ->ALUWB.
//  Retire: instret+1 on the cycle leaving for FETCH from MEMWR/MEMWB/ALUWB/BEQ; wraps modulo 2^CNT_W. JAL retires via ALUWB only (single count).
//  Timeout: wait cnt increments each cycle mem_req=1 & mem_ready=0, clears on mem_ready or state change; reaching MEM_TMO ->TRAP.
//  TRAP: all strobes 0, mem_req=0, trap=1; exit only by reset. mem_ready outside memory states ignored.
//  Reset mid-access drops mem_req the same edge; no partial retire counted.
// TESTING
//  Reset 3 cycles then release, mem_ready=1 always -> mem_req=1 in first cycle after reset, instret=0, trap=0.
//  add (0110011), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALUWB: 4 cycles, alu_op=00 in EXEC_R, reg_we=1 once, instret=1.
//  lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, reg_we only in MEMWB, total 8 cycles.
//  beq with zero=1 then zero=0 -> pc_we=1 in BEQ only for first, alu_op=11; instret=2 after both.
//  opcode 7'h7F -> DECODE->TRAP, trap=1 held 20 cycles, mem_req=0, instret unchanged; rst_n=0 clears.
//  MEM_TMO=16, mem_ready=0 in FETCH -> trap=1 after 16 wait cycles; MEM_TMO=0 -> waits indefinitely.

Source files
------------

// File: rtl/rv32i_mc_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback over the shared datapath, counts retired instructions and traps.
module rv32i_mc_ctrl #(
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  localparam int TMO_W = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_L = TMO_W'(MEM_TMO);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       mem_req_s, mem_we_s, adr_src_s, ir_we_s, reg_we_s, trap_s;
  logic       pc_update, branch, retire;
  logic [1:0] src_a_s, src_b_s, result_src_s, alu_op_s;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_we_s      = 1'b0;
    reg_we_s     = 1'b0;
    trap_s       = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    retire       = 1'b0;
    src_a_s      = 2'b00;
    src_b_s      = 2'b00;
    result_src_s = 2'b00;
    alu_op_s     = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        src_b_s      = 2'b10;
        alu_op_s     = 2'b01;
        result_src_s = 2'b10;
        if (mem_ready) begin
          ir_we_s   = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_s  = 2'b01;
        src_b_s  = 2'b01;
        alu_op_s = 2'b01;
        case (opcode)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_s  = 2'b10;
        src_b_s  = 2'b01;
        alu_op_s = 2'b01;
        state_d  = opcode[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_we_s     = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC_R: begin
        src_a_s = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_s  = 2'b10;
        src_b_s  = 2'b01;
        alu_op_s = 2'b10;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we_s = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        src_a_s  = 2'b10;
        alu_op_s = 2'b11;
        branch   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      // JAL only redirects the PC here; its single retire happens in ALUWB.
      S_JAL: begin
        src_a_s   = 2'b01;
        src_b_s   = 2'b10;
        alu_op_s  = 2'b01;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  trap_s  = 1'b1;
      default: state_d = S_TRAP;
    endcase

    // The wait count only survives a cycle spent stalled in the same access.
    wait_d = '0;
    if (MEM_TMO > 0 && mem_req_s && !mem_ready) begin
      wait_d = wait_q + 1'b1;
      if (wait_d == TMO_L) state_d = S_TRAP;
    end

    instret_d = instret_q + CNT_W'(retire);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign mem_req    = rst_n & mem_req_s;
  assign mem_we     = rst_n & mem_we_s;
  assign adr_src    = rst_n & adr_src_s;
  assign ir_we      = rst_n & ir_we_s;
  assign pc_we      = rst_n & (pc_update | (branch & zero));
  assign reg_we     = rst_n & reg_we_s;
  assign trap       = rst_n & trap_s;
  assign alu_src_a  = {2{rst_n}} & src_a_s;
  assign alu_src_b  = {2{rst_n}} & src_b_s;
  assign result_src = {2{rst_n}} & result_src_s;
  assign alu_op     = {2{rst_n}} & alu_op_s;
  assign instret    = rst_n ? instret_q : '0;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Self-checking bench for rv32i_mc_ctrl: a phase-level instruction model predicts
// every control output and the retire count cycle by cycle for two configurations.
module tb_rv32i_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        mem_req_a, mem_we_a, adr_src_a, ir_we_a, pc_we_a, reg_we_a, trap_a;
  logic [1:0]  src_a_a, src_b_a, rs_a, op_a;
  logic [31:0] instret_a;
  logic        mem_req_b, mem_we_b, adr_src_b, ir_we_b, pc_we_b, reg_we_b, trap_b;
  logic [1:0]  src_a_b, src_b_b, rs_b, op_b;
  logic [2:0]  instret_b;

  // Default configuration.
  rv32i_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .mem_we(mem_we_a), .adr_src(adr_src_a), .ir_we(ir_we_a),
    .pc_we(pc_we_a), .reg_we(reg_we_a), .alu_src_a(src_a_a), .alu_src_b(src_b_a),
    .result_src(rs_a), .alu_op(op_a), .trap(trap_a), .instret(instret_a)
  );

  // Timeout disabled, narrow counter so wrap-around is exercised.
  rv32i_mc_ctrl #(.MEM_TMO(0), .CNT_W(3)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .mem_we(mem_we_b), .adr_src(adr_src_b), .ir_we(ir_we_b),
    .pc_we(pc_we_b), .reg_we(reg_we_b), .alu_src_a(src_a_b), .alu_src_b(src_b_b),
    .result_src(rs_b), .alu_op(op_b), .trap(trap_b), .instret(instret_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, trap;
    logic [1:0] src_a, src_b, result_src, alu_op;
  } ctl_t;

  typedef enum {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWR, P_MEMWB,
    P_EXEC_R, P_EXEC_I, P_ALUWB, P_BEQ, P_JAL, P_TRAP, P_RESET
  } phase_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  ctl_t obs_a, obs_b;
  assign obs_a = {mem_req_a, mem_we_a, adr_src_a, ir_we_a, pc_we_a, reg_we_a, trap_a,
                  src_a_a, src_b_a, rs_a, op_a};
  assign obs_b = {mem_req_b, mem_we_b, adr_src_b, ir_we_b, pc_we_b, reg_we_b, trap_b,
                  src_a_b, src_b_b, rs_b, op_b};

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  // Control vector each phase of an instruction must present.
  function automatic ctl_t exp_ctl(phase_e p, logic rdy, logic z);
    ctl_t c = '0;
    case (p)
      P_FETCH:  begin c.mem_req = 1'b1; c.src_b = 2'b10; c.alu_op = 2'b01;
                      c.result_src = 2'b10; c.ir_we = rdy; c.pc_we = rdy; end
      P_DECODE: begin c.src_a = 2'b01; c.src_b = 2'b01; c.alu_op = 2'b01; end
      P_MEMADR: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b01; end
      P_MEMRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      P_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
      P_MEMWB:  begin c.result_src = 2'b01; c.reg_we = 1'b1; end
      P_EXEC_R: c.src_a = 2'b10;
      P_EXEC_I: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      P_ALUWB:  c.reg_we = 1'b1;
      P_BEQ:    begin c.src_a = 2'b10; c.alu_op = 2'b11; c.pc_we = z; end
      P_JAL:    begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 2'b01; c.pc_we = 1'b1; end
      P_TRAP:   c.trap = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: compare both instances mid-cycle, then advance past the next edge.
  task automatic cyc(input string tag, input phase_e pa, input phase_e pb);
    @(negedge clk);
    check({tag, "/ctl"}, 32'(obs_a), 32'(exp_ctl(pa, mem_ready, zero)));
    check({tag, "/instret"}, instret_a, 32'(exp_cnt));
    check({tag, "/ctl_nt"}, 32'(obs_b), 32'(exp_ctl(pb, mem_ready, zero)));
    check({tag, "/instret_nt"}, 32'(instret_b), 32'(exp_cnt % 8));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    exp_cnt = 0;
    repeat (n) cyc("reset", P_RESET, P_RESET);
    rst_n = 1'b1;
  endtask

  task automatic mem_phase(input phase_e p, input int d, input string tag);
    for (int i = 0; i < d; i++) begin
      mem_ready = 1'b0;
      cyc(tag, p, p);
    end
    mem_ready = 1'b1;
    cyc(tag, p, p);
  endtask

  task automatic run_instr(input logic [6:0] opc, input int fd, input int md, input logic z);
    opcode = opc;
    zero = z;
    mem_phase(P_FETCH, fd, "fetch");
    mem_ready = 1'($urandom);
    cyc("decode", P_DECODE, P_DECODE);
    case (opc)
      OP_LW, OP_SW: begin
        mem_ready = 1'($urandom);
        cyc("memadr", P_MEMADR, P_MEMADR);
        if (opc[5]) begin
          mem_phase(P_MEMWR, md, "memwr");
        end else begin
          mem_phase(P_MEMRD, md, "memrd");
          mem_ready = 1'($urandom);
          cyc("memwb", P_MEMWB, P_MEMWB);
        end
        exp_cnt++;
      end
      OP_R, OP_I: begin
        mem_ready = 1'($urandom);
        if (opc == OP_R) cyc("exec_r", P_EXEC_R, P_EXEC_R);
        else             cyc("exec_i", P_EXEC_I, P_EXEC_I);
        mem_ready = 1'($urandom);
        cyc("aluwb", P_ALUWB, P_ALUWB);
        exp_cnt++;
      end
      OP_BEQ: begin
        mem_ready = 1'($urandom);
        cyc("beq", P_BEQ, P_BEQ);
        exp_cnt++;
      end
      OP_JAL: begin
        mem_ready = 1'($urandom);
        cyc("jal", P_JAL, P_JAL);
        mem_ready = 1'($urandom);
        cyc("jal_wb", P_ALUWB, P_ALUWB);
        exp_cnt++;
      end
      default: begin
        for (int i = 0; i < 20; i++) begin
          mem_ready = 1'($urandom);
          cyc("trap", P_TRAP, P_TRAP);
        end
      end
    endcase
  endtask

  logic [6:0] ops [6];

  initial begin
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    do_reset(3);
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_SW, 2, 1, 1'b1);
    run_instr(OP_I, 0, 0, 1'b1);
    run_instr(OP_JAL, 1, 0, 1'b0);
    // Longest stalls that must not trap.
    run_instr(OP_LW, 15, 15, 1'b0);
    run_instr(OP_SW, 15, 15, 1'b1);

    for (int k = 0; k < 60; k++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 15), $urandom_range(0, 15),
                1'($urandom));

    // Illegal opcode traps both instances and freezes the count.
    run_instr(7'h7F, 0, 0, 1'b0);
    do_reset(2);
    run_instr(OP_R, 0, 0, 1'b0);

    // Reset in the middle of a stalled load: request drops, nothing retires.
    opcode = OP_LW;
    mem_phase(P_FETCH, 0, "mid_fetch");
    cyc("mid_decode", P_DECODE, P_DECODE);
    cyc("mid_memadr", P_MEMADR, P_MEMADR);
    mem_ready = 1'b0;
    cyc("mid_memrd", P_MEMRD, P_MEMRD);
    cyc("mid_memrd", P_MEMRD, P_MEMRD);
    do_reset(1);
    run_instr(OP_I, 0, 0, 1'b0);

    // Fetch never completes: default instance traps after 16 waits, other waits on.
    mem_ready = 1'b0;
    opcode = OP_R;
    for (int i = 0; i < 16; i++) cyc("tmo_wait", P_FETCH, P_FETCH);
    for (int i = 0; i < 20; i++) cyc("tmo_trap", P_TRAP, P_FETCH);
    do_reset(1);
    run_instr(OP_R, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
